// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer feeding the IF/ID register.
// Issues sequential fetches over a req/ack port, holds up to DEPTH {pc, instr}
// pairs, presents the oldest pair to IF/ID and flushes everything on redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     keep,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     fpc;
    logic [31:0]     fpcNext;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [31:0]     pcMem    [DEPTH];
    logic [31:0]     instrMem [DEPTH];
    logic            push;
    logic            pop;
    logic [CW-1:0]   countAfterPush;
    logic            roomAfterPush;
    logic            roomNow;

    // Handshake qualifiers and next fetch address; redirect wins over everything.
    always_comb begin
        push           = (state == FETCH) && imem_ack && !redirect;
        pop            = out_valid && !keep;
        countAfterPush = count + CW'(1) - CW'(pop);
        roomAfterPush  = countAfterPush < CW'(DEPTH);
        roomNow        = count < CW'(DEPTH);
        fpcNext        = fpc;
        if (redirect) begin
            fpcNext = redirect_pc;
        end else if (push) begin
            fpcNext = fpc + 32'd4;
        end
    end

    // Head of the circular buffer drives IF/ID; zeros when nothing is buffered.
    always_comb begin
        out_valid = (count != '0);
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = pcMem[rdPtr];
            out_instr = instrMem[rdPtr];
        end
    end

    // Fetch controller: registered request/address, single outstanding request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fpc       <= RESET_PC;
        end else begin
            fpc <= fpcNext;
            case (state)
                IDLE: begin
                    imem_addr <= fpcNext;
                    if (!redirect && roomNow) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            // Word arriving with the redirect is simply discarded.
                            state     <= IDLE;
                            imem_req  <= 1'b0;
                            imem_addr <= fpcNext;
                        end else begin
                            // Keep the old request up until the memory answers it.
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        imem_addr <= fpcNext;
                        if (!roomAfterPush) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state     <= IDLE;
                        imem_req  <= 1'b0;
                        imem_addr <= fpcNext;
                    end
                end
                default: begin
                    state     <= IDLE;
                    imem_req  <= 1'b0;
                    imem_addr <= fpcNext;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; written only on an accepted fetch response.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            pcMem[wrPtr]    <= fpc;
            instrMem[wrPtr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Testbench for fetch_queue: bench acts as instruction memory and IF/ID
// consumer, keeps a reference queue of expected {pc, instr} pairs.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 keep;
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic                 imem_ack;
    logic [31:0]          imem_rdata;
    logic                 out_valid;
    logic [31:0]          out_pc;
    logic [31:0]          out_instr;
    logic [CW-1:0]        count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .keep       (keep),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [63:0] expQ[$];
    logic [31:0] expFetch = RESET_PC;
    bit          dropping = 1'b0;
    logic [31:0] dropAddr = '0;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: check state against the reference, drive inputs, update reference.
    task automatic cycle(input bit ackW, input bit keepV, input bit redir,
                         input logic [31:0] rpc, input bit rstV);
        logic [31:0] reqAddr;
        @(negedge clk);
        nCompared++;
        if (count !== CW'(expQ.size())) begin
            nMismatched++;
            $display("FAIL count: got %0d expected %0d", count, expQ.size());
        end
        nCompared++;
        if (out_valid !== (expQ.size() != 0)) begin
            nMismatched++;
            $display("FAIL out_valid: got %b expected %b", out_valid, expQ.size() != 0);
        end
        if (expQ.size() == 0) begin
            nCompared++;
            if (out_pc !== '0 || out_instr !== '0) begin
                nMismatched++;
                $display("FAIL empty_out: got pc %h instr %h expected 0/0", out_pc, out_instr);
            end
        end else begin
            nCompared++;
            if ({out_pc, out_instr} !== expQ[0]) begin
                nMismatched++;
                $display("FAIL head: got pc %h instr %h expected pc %h instr %h",
                         out_pc, out_instr, expQ[0][63:32], expQ[0][31:0]);
            end
        end
        reqAddr     = dropping ? dropAddr : expFetch;
        reset       = rstV;
        keep        = keepV;
        redirect    = redir;
        redirect_pc = rpc;
        imem_ack    = ackW && (imem_req === 1'b1);
        imem_rdata  = imem_ack ? instrOf(reqAddr) : 32'hDEAD_BEEF;
        #1;
        if (imem_req === 1'b1) begin
            nCompared++;
            if (imem_addr !== reqAddr) begin
                nMismatched++;
                $display("FAIL imem_addr: got %h expected %h", imem_addr, reqAddr);
            end
        end
        if (!rstV) begin
            expQ.delete();
            expFetch = RESET_PC;
            dropping = 1'b0;
        end else if (redir) begin
            expQ.delete();
            if (imem_req === 1'b1) begin
                if (dropping) begin
                    if (imem_ack) dropping = 1'b0;
                end else if (!imem_ack) begin
                    dropping = 1'b1;
                    dropAddr = expFetch;
                end
            end
            expFetch = rpc;
        end else begin
            if (expQ.size() != 0 && !keepV) void'(expQ.pop_front());
            if (imem_ack) begin
                if (dropping) begin
                    dropping = 1'b0;
                end else begin
                    expQ.push_back({expFetch, instrOf(expFetch)});
                    expFetch += 32'd4;
                end
            end
        end
    endtask

    task automatic doReset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            nMismatched++;
            $display("FAIL reset_req: got req %b addr %h expected 0 %h", imem_req, imem_addr, RESET_PC);
        end
        nCompared++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_instr !== '0 || count !== '0) begin
            nMismatched++;
            $display("FAIL reset_out: got v %b pc %h instr %h cnt %0d expected all 0",
                     out_valid, out_pc, out_instr, count);
        end
    endtask

    task automatic test_stream();
        doReset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (imem_req !== 1'b0) begin
            nMismatched++;
            $display("FAIL stream_c0_req: got %b expected 0", imem_req);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            nMismatched++;
            $display("FAIL stream_c1_req: got req %b addr %h expected 1 %h", imem_req, imem_addr, RESET_PC);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            nCompared++;
            if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * i) || count > CW'(1)) begin
                nMismatched++;
                $display("FAIL stream_seq: got v %b pc %h cnt %0d expected 1 %h <=1",
                         out_valid, out_pc, count, RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_fill_stall();
        bit seen = 1'b0;
        doReset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            nCompared++;
            if (imem_req !== 1'b0 || count !== CW'(DEPTH) || out_pc !== RESET_PC) begin
                nMismatched++;
                $display("FAIL fill_full: got req %b cnt %0d pc %h expected 0 %0d %h",
                         imem_req, count, out_pc, DEPTH, RESET_PC);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (i < 4) begin
                nCompared++;
                if (out_pc !== RESET_PC + 32'(4 * i)) begin
                    nMismatched++;
                    $display("FAIL fill_drain: got %h expected %h", out_pc, RESET_PC + 32'(4 * i));
                end
            end
            if (imem_req === 1'b1 && !seen) begin
                seen = 1'b1;
                nCompared++;
                if (imem_addr !== RESET_PC + 32'h10) begin
                    nMismatched++;
                    $display("FAIL fill_resume: got %h expected %h", imem_addr, RESET_PC + 32'h10);
                end
            end
        end
        nCompared++;
        if (!seen) begin
            nMismatched++;
            $display("FAIL fill_resume_timeout: got no request expected request at %h", RESET_PC + 32'h10);
        end
    endtask

    task automatic test_redirect_ack();
        bit seenReq = 1'b0;
        bit seenOut = 1'b0;
        doReset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h3100, 1'b1);
        nCompared++;
        if (imem_addr !== 32'h3008 || imem_ack !== 1'b1) begin
            nMismatched++;
            $display("FAIL redir_ack_addr: got addr %h ack %b expected 3008 1", imem_addr, imem_ack);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (count !== '0 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
            nMismatched++;
            $display("FAIL redir_ack_flush: got cnt %0d v %b req %b expected 0 0 0", count, out_valid, imem_req);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req === 1'b1 && !seenReq) begin
                seenReq = 1'b1;
                nCompared++;
                if (imem_addr !== 32'h3100) begin
                    nMismatched++;
                    $display("FAIL redir_ack_newreq: got %h expected 00003100", imem_addr);
                end
            end
            if (out_valid === 1'b1 && !seenOut) begin
                seenOut = 1'b1;
                nCompared++;
                if (out_pc !== 32'h3100) begin
                    nMismatched++;
                    $display("FAIL redir_ack_first: got %h expected 00003100", out_pc);
                end
            end
        end
        nCompared++;
        if (!seenReq || !seenOut) begin
            nMismatched++;
            $display("FAIL redir_ack_timeout: got req %b out %b expected 1 1", seenReq, seenOut);
        end
    endtask

    task automatic test_redirect_wait();
        bit seenReq = 1'b0;
        bit seenOut = 1'b0;
        doReset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h3200, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle((i == 2), 1'b0, 1'b0, 32'h0, 1'b1);
            nCompared++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
                nMismatched++;
                $display("FAIL redir_wait_hold: got req %b addr %h expected 1 00003004", imem_req, imem_addr);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req === 1'b1 && !seenReq) begin
                seenReq = 1'b1;
                nCompared++;
                if (imem_addr !== 32'h3200) begin
                    nMismatched++;
                    $display("FAIL redir_wait_newreq: got %h expected 00003200", imem_addr);
                end
            end
            if (out_valid === 1'b1 && !seenOut) begin
                seenOut = 1'b1;
                nCompared++;
                if (out_pc !== 32'h3200) begin
                    nMismatched++;
                    $display("FAIL redir_wait_first: got %h expected 00003200", out_pc);
                end
            end
        end
        nCompared++;
        if (!seenReq || !seenOut) begin
            nMismatched++;
            $display("FAIL redir_wait_timeout: got req %b out %b expected 1 1", seenReq, seenOut);
        end
    endtask

    task automatic test_push_pop();
        doReset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            nCompared++;
            if (count !== CW'(2) || out_pc !== RESET_PC + 32'(4 * i)) begin
                nMismatched++;
                $display("FAIL push_pop: got cnt %0d pc %h expected 2 %h",
                         count, out_pc, RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
            nMismatched++;
            $display("FAIL reset_mid: got req %b v %b cnt %0d expected 0 0 0", imem_req, out_valid, count);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            nMismatched++;
            $display("FAIL reset_mid_restart: got req %b addr %h expected 1 %h", imem_req, imem_addr, RESET_PC);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        nCompared++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
            nMismatched++;
            $display("FAIL reset_mid_first: got v %b pc %h expected 1 %h", out_valid, out_pc, RESET_PC);
        end
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        keep        = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_stream();
        test_fill_stall();
        test_redirect_ack();
        test_redirect_wait();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000ns");
        $fatal(1);
    end

endmodule
